stream64b_to_32b_unpacker: RTL and testbench



---
 rtl/stream64b_to_32b_unpacker_pkg.sv | 19 +
 rtl/stream64b_to_32b_unpacker_lane_slice_mux.sv | 28 ++
 rtl/stream64b_to_32b_unpacker.sv | 125 ++++++++++++
 tb/tb_stream64b_to_32b_unpacker.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream64b_to_32b_unpacker_pkg.sv
// Shared constants for the activation stream packer/unpacker pair.
//   ACT_DATA_WIDTH : bits per activation lane
//   N_DIM_ARRAY    : lanes in one wide activation-memory word
//   UNPACK_RATIO   : narrow beats per wide word at the default configuration
//   BEAT_W         : width of the beat counter at the default configuration
//   unpack_state_e : holding-register occupancy for the unpacker
package stream64b_to_32b_unpacker_pkg;

  localparam int unsigned ACT_DATA_WIDTH = 8;
  localparam int unsigned N_DIM_ARRAY    = 8;
  localparam int unsigned UNPACK_RATIO   = 2;
  localparam int unsigned BEAT_W         = $clog2(UNPACK_RATIO);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } unpack_state_e;

endpackage

// File: rtl/stream64b_to_32b_unpacker_lane_slice_mux.sv
// Generic wide-to-narrow lane selector.
//   in_word  : IN_LANES lanes of LANE_W bits
//   sel      : index of the OUT_LANES-wide group to forward (group 0 = lowest lanes)
//   out_word : selected OUT_LANES lanes, copied bit-exactly
module lane_slice_mux #(
  parameter int unsigned LANE_W    = 8,
  parameter int unsigned IN_LANES  = 8,
  parameter int unsigned OUT_LANES = 4,
  parameter int unsigned SEL_W     = 1
) (
  input  logic [IN_LANES*LANE_W-1:0]  in_word,
  input  logic [SEL_W-1:0]            sel,
  output logic [OUT_LANES*LANE_W-1:0] out_word
);

  localparam int unsigned RATIO = IN_LANES / OUT_LANES;
  localparam int unsigned OUT_W = OUT_LANES * LANE_W;

  always_comb begin
    out_word = '0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (sel == SEL_W'(k)) begin
        out_word = in_word[k*OUT_W +: OUT_W];
      end
    end
  end

endmodule

// File: rtl/stream64b_to_32b_unpacker.sv
// Splits one wide activation word into RATIO = IN_LANES/OUT_LANES narrow beats,
// least-significant lanes first, with a per-beat address.
//   clk, reset (async, active-low), clear (sync flush of held word/beat count)
//   in_valid/in_ready/in_word/in_addr      : wide-word input handshake
//   out_valid/out_ready/out_word/out_addr  : narrow-beat output handshake
//   out_last                               : final beat of the current wide word
// Sustains one beat per cycle: the next word is accepted on the last beat.
module stream64b_to_32b_unpacker #(
  parameter int unsigned ACT_DATA_WIDTH = stream64b_to_32b_unpacker_pkg::ACT_DATA_WIDTH,
  parameter int unsigned IN_LANES       = 8,
  parameter int unsigned OUT_LANES      = 4,
  parameter int unsigned ADDR_WIDTH     = 32
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   clear,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic signed [IN_LANES*ACT_DATA_WIDTH-1:0]  in_word,
  input  logic        [ADDR_WIDTH-1:0]           in_addr,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic signed [OUT_LANES*ACT_DATA_WIDTH-1:0] out_word,
  output logic        [ADDR_WIDTH-1:0]           out_addr,
  output logic                                   out_last
);

  import stream64b_to_32b_unpacker_pkg::*;

  localparam int unsigned RATIO  = IN_LANES / OUT_LANES;
  localparam int unsigned BEAT_B = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned IN_W   = IN_LANES * ACT_DATA_WIDTH;

  if ((RATIO < 2) || ((RATIO & (RATIO - 1)) != 0) || (IN_LANES % OUT_LANES != 0)) begin : g_bad_ratio
    $error("IN_LANES/OUT_LANES must be a power of two >= 2");
  end

  unpack_state_e           state_q, state_d;
  logic [BEAT_B-1:0]       beat_q, beat_d;
  logic [IN_W-1:0]         hold_word_q, hold_word_d;
  logic [ADDR_WIDTH-1:0]   hold_addr_q, hold_addr_d;

  logic accept;
  logic fire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      beat_q      <= '0;
      hold_word_q <= '0;
      hold_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      hold_word_q <= hold_word_d;
      hold_addr_q <= hold_addr_d;
    end
  end

  lane_slice_mux #(
    .LANE_W    (ACT_DATA_WIDTH),
    .IN_LANES  (IN_LANES),
    .OUT_LANES (OUT_LANES),
    .SEL_W     (BEAT_B)
  ) u_lane_slice_mux (
    .in_word  (hold_word_q),
    .sel      (beat_q),
    .out_word (out_word)
  );

  // RATIO is a power of two and beat < RATIO, so hold_addr*RATIO + beat is a
  // shift with the beat filling the vacated low bits; the shift drops the
  // high bits, giving the modulo-2^ADDR_WIDTH wrap.
  assign out_addr = (hold_addr_q << BEAT_B) | ADDR_WIDTH'(beat_q);

  always_comb begin
    out_valid = (state_q == ST_FULL);
    out_last  = out_valid && (beat_q == BEAT_B'(RATIO - 1));
    in_ready  = (state_q == ST_EMPTY) || (out_last && out_ready);
    accept    = in_valid && in_ready;
    fire      = out_valid && out_ready;
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    hold_word_d = hold_word_q;
    hold_addr_d = hold_addr_q;
    if (clear) begin
      // Flush wins over any same-cycle accept; held data is left in place.
      state_d = ST_EMPTY;
      beat_d  = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            hold_word_d = in_word;
            hold_addr_d = in_addr;
            beat_d      = '0;
            state_d     = ST_FULL;
          end
        end
        ST_FULL: begin
          if (fire) begin
            if (!out_last) begin
              beat_d = beat_q + BEAT_B'(1);
            end else if (accept) begin
              hold_word_d = in_word;
              hold_addr_d = in_addr;
              beat_d      = '0;
            end else begin
              beat_d  = '0;
              state_d = ST_EMPTY;
            end
          end
        end
        default: begin
          state_d = ST_EMPTY;
          beat_d  = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream64b_to_32b_unpacker.sv
module tb_stream64b_to_32b_unpacker;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_word;
  logic [31:0] in_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [31:0] out_addr;
  logic        out_last;

  logic         in_valid16;
  logic         in_ready16;
  logic [127:0] in_word16;
  logic [31:0]  in_addr16;
  logic         out_valid16;
  logic         out_ready16;
  logic [31:0]  out_word16;
  logic [31:0]  out_addr16;
  logic         out_last16;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  stream64b_to_32b_unpacker dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .in_addr   (in_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_addr  (out_addr),
    .out_last  (out_last)
  );

  stream64b_to_32b_unpacker #(
    .ACT_DATA_WIDTH (8),
    .IN_LANES       (16),
    .OUT_LANES      (4),
    .ADDR_WIDTH     (32)
  ) dut16 (
    .clk       (clk),
    .reset     (reset),
    .clear     (1'b0),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .in_word   (in_word16),
    .in_addr   (in_addr16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .out_word  (out_word16),
    .out_addr  (out_addr16),
    .out_last  (out_last16)
  );

  // Reference model: a queue of the narrow beats still owed downstream.
  typedef struct {
    logic [31:0] w;
    logic [31:0] a;
    bit          last;
  } beat_t;

  beat_t q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [63:0] w, input logic [31:0] a);
    beat_t b;
    for (int k = 0; k < 2; k++) begin
      b.w    = 32'(w >> (32 * k));
      b.a    = 32'(a * 32'd2 + 32'(k));
      b.last = (k == 1);
      q.push_back(b);
    end
  endtask

  // One clock cycle: drive inputs mid-cycle, compare against the model, advance.
  task automatic cycle(input bit ivld, input logic [63:0] w, input logic [31:0] a,
                       input bit ordy, input bit clr, output bit acc);
    bit exp_vld;
    bit exp_rdy;
    in_valid  = ivld;
    in_word   = w;
    in_addr   = a;
    out_ready = ordy;
    clear     = clr;
    #1;
    exp_vld = (q.size() != 0);
    exp_rdy = (q.size() == 0) || (q.size() == 1 && ordy);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(exp_vld));
    if (exp_vld) begin
      chk("out_word", 64'(out_word), 64'(q[0].w));
      chk("out_addr", 64'(out_addr), 64'(q[0].a));
      chk("out_last", 64'(out_last), 64'(q[0].last));
    end
    acc = ivld && exp_rdy && !clr;
    if (clr) begin
      q.delete();
    end else begin
      if (exp_vld && ordy) void'(q.pop_front());
      if (acc) push_word(w, a);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    int unsigned nv;
    int unsigned idx;
    logic [63:0] ws [3];
    logic [31:0] exp16 [4];

    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_word = '0; in_addr = '0; out_ready = 1'b0;
    in_valid16 = 1'b0; in_word16 = '0; in_addr16 = '0; out_ready16 = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_word", 64'(out_word), 64'd0);
    chk("rst_out_addr", 64'(out_addr), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single word at defaults
    cycle(1'b1, 64'h8877665544332211, 32'h10, 1'b1, 1'b0, acc);
    chk("single_acc", 64'(acc), 64'd1);
    chk("single_b0_word", 64'(out_word), 64'h44332211);
    chk("single_b0_addr", 64'(out_addr), 64'h20);
    chk("single_b0_last", 64'(out_last), 64'd0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
    chk("single_b1_word", 64'(out_word), 64'h88776655);
    chk("single_b1_addr", 64'(out_addr), 64'h21);
    chk("single_b1_last", 64'(out_last), 64'd1);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
    chk("single_done_valid", 64'(out_valid), 64'd0);
    chk("single_done_ready", 64'(in_ready), 64'd1);

    // Back-to-back: three words with in_valid held high
    ws[0] = 64'hA1A2A3A4_B1B2B3B4;
    ws[1] = 64'h0102030405060708;
    ws[2] = 64'hFFEEDDCC_BBAA9988;
    idx = 0;
    nv  = 0;
    for (int c = 0; c < 8; c++) begin
      cycle(idx < 3, (idx < 3) ? ws[idx] : 64'd0, 32'h100 * (idx + 1), 1'b1, 1'b0, acc);
      if (acc) idx++;
      if (out_valid) nv++;
    end
    chk("b2b_words", 64'(idx), 64'd3);
    chk("b2b_beats", 64'(nv), 64'd6);

    // Backpressure during beat 1
    cycle(1'b1, 64'hDEADBEEF_CAFEF00D, 32'h40, 1'b1, 1'b0, acc);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
    for (int c = 0; c < 5; c++) begin
      cycle(1'b1, 64'h1111111122222222, 32'h55, 1'b0, 1'b0, acc);
      chk("bp_word", 64'(out_word), 64'hDEADBEEF);
      chk("bp_addr", 64'(out_addr), 64'h81);
      chk("bp_last", 64'(out_last), 64'd1);
    end
    cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
    chk("bp_done", 64'(out_valid), 64'd0);

    // Address wrap
    cycle(1'b1, 64'h0123456789ABCDEF, 32'h80000000, 1'b1, 1'b0, acc);
    chk("wrap_b0", 64'(out_addr), 64'h0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
    chk("wrap_b1", 64'(out_addr), 64'h1);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);

    // Clear at beat 0 with a word on offer
    cycle(1'b1, 64'h5555AAAA5555AAAA, 32'h9, 1'b1, 1'b0, acc);
    cycle(1'b1, 64'h7777777766666666, 32'hA, 1'b1, 1'b1, acc);
    chk("clr_acc", 64'(acc), 64'd0);
    chk("clr_valid", 64'(out_valid), 64'd0);
    chk("clr_ready", 64'(in_ready), 64'd1);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);

    // Reset mid-word
    cycle(1'b1, 64'h1234567890ABCDEF, 32'h33, 1'b1, 1'b0, acc);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
    reset = 1'b0;
    #1;
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_last", 64'(out_last), 64'd0);
    chk("mrst_word", 64'(out_word), 64'd0);
    chk("mrst_addr", 64'(out_addr), 64'd0);
    chk("mrst_ready", 64'(in_ready), 64'd1);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, 64'hCAFEBABE_8BADF00D, 32'h7, 1'b1, 1'b0, acc);
    chk("post_rst_addr", 64'(out_addr), 64'hE);
    chk("post_rst_word", 64'(out_word), 64'h8BADF00D);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);

    // Randomized traffic against the model
    for (int c = 0; c < 300; c++) begin
      cycle(1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, acc);
    end
    for (int c = 0; c < 3; c++) cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);

    // RATIO = 4 instance: lanes 0..15 hold 0x00..0x0F
    exp16[0] = 32'h03020100;
    exp16[1] = 32'h07060504;
    exp16[2] = 32'h0B0A0908;
    exp16[3] = 32'h0F0E0D0C;
    for (int l = 0; l < 16; l++) in_word16[l*8 +: 8] = 8'(l);
    in_addr16  = 32'h5;
    in_valid16 = 1'b1;
    #1;
    chk("r4_in_ready", 64'(in_ready16), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid16 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("r4_valid", 64'(out_valid16), 64'd1);
      chk("r4_word", 64'(out_word16), 64'(exp16[k]));
      chk("r4_addr", 64'(out_addr16), 64'(32'h14 + 32'(k)));
      chk("r4_last", 64'(out_last16), 64'(k == 3));
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    chk("r4_done", 64'(out_valid16), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
